// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between an instruction-fetch requester
//   (read-only) and a load/store data requester. One access is in flight at a
//   time: the grant is issued combinationally in IDLE, the arbiter then waits
//   MEM_LAT cycles for read data, and pulses the winner's rvalid for one cycle.
//
//   Optional feature: define MEM_ARB_RR_EN to resolve contention round-robin
//   (the requester not granted most recently wins). Without it, data always
//   wins over fetch.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata     fetch grant, response strobe, read data
//   d_req/d_we/d_addr/d_wdata     data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata        data grant, response strobe, read data (0 on writes)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           shared memory port
//   conflict_cnt                  saturating count of IDLE cycles with both requests high
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1     // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_e;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e      state_q;
  src_e        owner_q;      // requester that owns the access in flight
  logic        owner_we_q;   // access in flight is a write
  logic [2:0]  lat_q;        // WAIT cycles elapsed
  logic        if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [15:0] cnt_q, cnt_d;

  logic idle;      // arbiter may grant this cycle
  logic grant;
  logic win_d;     // data requester wins the current arbitration
  logic both_req;

`ifdef MEM_ARB_RR_EN
  src_e last_q;    // requester granted most recently
`endif

  // Gated by reset so nothing is granted while reset is held low.
  assign idle     = (state_q == IDLE) && reset;
  assign both_req = if_req && d_req;
  assign grant    = idle && (if_req || d_req);

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    win_d = d_req;
`ifdef MEM_ARB_RR_EN
    if (both_req) win_d = (last_q == SRC_IF);
`endif
  end

  assign if_gnt    = grant && !win_d;
  assign d_gnt     = grant && win_d;
  assign mem_en    = grant;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = win_d ? d_addr : if_addr;
  assign mem_wdata = win_d ? d_wdata : '0;

  // Contention counter saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (idle && both_req && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= SRC_IF;
      owner_we_q  <= 1'b0;
      lat_q       <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= SRC_IF;
`endif
    end else begin
      cnt_q       <= cnt_d;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q    <= win_d ? SRC_D : SRC_IF;
            owner_we_q <= mem_we;
            lat_q      <= '0;
            state_q    <= WAIT;
`ifdef MEM_ARB_RR_EN
            last_q     <= win_d ? SRC_D : SRC_IF;
`endif
          end
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            // Read data is valid on mem_rdata during the last WAIT cycle.
            if (owner_q == SRC_D) begin
              d_rdata_q  <= owner_we_q ? '0 : mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid    = if_rvalid_q;
  assign d_rvalid     = d_rvalid_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width in bits.
REQ-003 SHALL have parameter MEM_LAT, default 1, read latency of the memory in cycles; legal range 1..7.
REQ-004 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports if_req (input, 1), if_addr (input, ADDR_W), if_gnt (output, 1), if_rvalid (output, 1), if_rdata (output, DATA_W): the instruction-fetch requester; fetch is read-only.
REQ-007 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDR_W), d_wdata (input, DATA_W), d_gnt (output, 1), d_rvalid (output, 1), d_rdata (output, DATA_W): the LW/SW data requester.
REQ-008 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W): the single shared memory port.
REQ-009 SHALL have port conflict_cnt  output  16  count of cycles in which both requesters were granted-eligible at the same time.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-011 In IDLE with at least one req high, SHALL assert exactly one gnt combinationally that cycle (cycle T) and drive mem_en=1, with mem_addr, mem_we and mem_wdata taken from the winner; mem_we SHALL be 0 for a fetch.
REQ-012 SHALL assert gnt, mem_en and mem_we only in IDLE; outside IDLE all three SHALL be 0 and mem_addr/mem_wdata are don't-care.
REQ-013 SHALL move IDLE->WAIT on grant, stay in WAIT for MEM_LAT cycles, capture mem_rdata into the winner's rdata register at the final WAIT edge, then move WAIT->RESP.
REQ-014 In RESP, SHALL pulse the winner's rvalid for exactly one cycle (cycle T+MEM_LAT+1), then move RESP->IDLE; earliest next grant is T+MEM_LAT+2.
REQ-015 Every grant SHALL produce exactly one rvalid to the same requester; for a write the rdata register SHALL be loaded with 0.
REQ-016 if_rdata/d_rdata SHALL hold their last value until that requester's next response.
REQ-017 Requesters hold req, addr and wdata until gnt; a req dropped before its grant SHALL be ignored with no side effects; req state outside IDLE SHALL be ignored.
REQ-018 Fixed priority (macro absent): on simultaneous if_req and d_req in IDLE, data SHALL win.
REQ-019 conflict_cnt SHALL increment by 1 in each IDLE cycle with if_req=d_req=1 and saturate at 0xFFFF.
REQ-020 A requester SHALL have at most one outstanding access; a new grant SHALL never be issued before the prior rvalid.

Reset
REQ-021 While reset=0, SHALL force state to IDLE, all gnt/rvalid/mem_en/mem_we to 0, rdata registers and conflict_cnt to 0, and the round-robin pointer to "last=fetch", independent of clk.
REQ-022 Reset during WAIT or RESP SHALL abandon the access: no rvalid after reset release, first grant possible in the first IDLE cycle after release.

Configuration
REQ-023 Macro MEM_ARB_RR_EN: when defined, contention SHALL be resolved round-robin. The requester not granted most recently wins, and the pointer updates on every grant. When undefined, REQ-018 fixed priority applies and no pointer register exists.

Verification (MEM_LAT=2)
REQ-024 Reset: hold reset=0 with if_req=d_req=1 -> all gnt/rvalid/mem_en=0, conflict_cnt=0, rdata=0.
REQ-025 Fetch: if_req, if_addr=0x0, mem returns 0x20020000 -> if_gnt and mem_en at T, if_rvalid only at T+3, if_rdata=0x20020000 held afterwards.
REQ-026 Store: d_req, d_we=1, d_addr=0x3FC, d_wdata=0x3A -> mem_we=1 and mem_wdata=0x3A at T, d_rvalid at T+3, d_rdata=0.
REQ-027 Contention, macro off: both req held high -> d_gnt at T, if_gnt at T+4, conflict_cnt=1 after first IDLE cycle.
REQ-028 Contention, MEM_ARB_RR_EN on: both req held for 4 grants -> grant order d, if, d, if at T, T+4, T+8, T+12.
REQ-029 Reset asserted at T+1 of a read -> no rvalid ever for it; after release, a new if_req is granted in the first cycle.
